// File: rtl/decompress_seq_ctrl.sv
// decompress_seq_ctrl: streams a packed polynomial from RAM, unpacks it and sequences the decompress datapath
module decompress_seq_ctrl #(
    parameter int D      = 4,
    parameter int N      = 256,
    parameter int W      = 32,
    parameter int DP_LAT = 4,
    parameter int IN_AW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [IN_AW-1:0]     mem_addr,
    input  logic [W-1:0]         mem_rd_data,
    output logic [D-1:0]         dp_in_val,
    input  logic [11:0]          dp_out_val,
    output logic                 coef_we,
    output logic [$clog2(N)-1:0] coef_addr,
    output logic [11:0]          coef_data
);
    localparam int CW = $clog2(N);
    localparam int BW = $clog2(3 * W + 1);
    localparam logic [IN_AW:0] WORDS = (IN_AW + 1)'((N * D + W - 1) / W);
    localparam logic [CW:0]    NLAST = (CW + 1)'(N - 1);
    localparam logic [CW:0]    NL    = (CW + 1)'(N);
    localparam logic [BW-1:0]  DL    = BW'(D);
    localparam logic [BW-1:0]  WL    = BW'(W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t          state, state_nx;
    logic [2*W-1:0]  bits;
    logic [BW-1:0]   cnt, cnt_nx;
    logic [IN_AW:0]  rd_cnt;
    logic [CW:0]     iss_cnt;
    logic [CW-1:0]   wr_cnt;
    logic            inflight;
    logic [DP_LAT-1:0] vld;
    logic            issue, last_wr, launch;

    // Issue/read decisions, output decode and next state
    always_comb begin
        launch    = state == IDLE && start;
        issue     = state == RUN && cnt >= DL && iss_cnt < NL;
        cnt_nx    = cnt - (issue ? DL : '0);
        mem_rd_en = state == RUN && rd_cnt < WORDS && cnt_nx + (inflight ? WL : '0) <= WL;
        mem_addr  = mem_rd_en ? rd_cnt[IN_AW-1:0] : '0;
        coef_we   = vld[DP_LAT-1];
        coef_addr = coef_we ? wr_cnt : '0;
        coef_data = coef_we ? dp_out_val : '0;
        last_wr   = coef_we && wr_cnt == CW'(N - 1);
        busy      = state != IDLE;
        done      = state == FIN;
        state_nx  = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = issue && iss_cnt == NLAST ? DRAIN : RUN;
            DRAIN:   state_nx = last_wr ? FIN : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Bit buffer, counters and result tagging; all cleared at the start of a run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || launch) begin
            bits      <= '0;
            cnt       <= '0;
            rd_cnt    <= '0;
            iss_cnt   <= '0;
            wr_cnt    <= '0;
            inflight  <= 1'b0;
            vld       <= '0;
            dp_in_val <= '0;
        end else begin
            inflight  <= mem_rd_en;
            rd_cnt    <= rd_cnt + (IN_AW + 1)'(mem_rd_en);
            bits      <= (issue ? bits >> D : bits) | (inflight ? {{W{1'b0}}, mem_rd_data} << cnt_nx : '0);
            cnt       <= cnt_nx + (inflight ? WL : '0);
            iss_cnt   <= iss_cnt + (CW + 1)'(issue);
            dp_in_val <= issue ? bits[D-1:0] : '0;
            vld       <= (vld << 1) | DP_LAT'(issue);
            wr_cnt    <= wr_cnt + CW'(coef_we);
        end
    end
endmodule

// File: tb/tb_decompress_seq_ctrl.sv
// tb_decompress_seq_ctrl: scoreboard bench running D=4, 10 and 11 controllers side by side
module tb_decompress_seq_ctrl;
    localparam int N = 256;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    int   cyc = 0;
    int   t0 = 0;
    int   checks = 0;
    int   errors = 0;
    int   dv [3] = '{4, 10, 11};
    int   words [3];
    logic [W-1:0] mem [3][256];
    logic [11:0]  exp_q [3][$];
    int   rd_idx [3];
    int   wr_idx [3];
    bit   active [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: coefficient k is bits k*D .. k*D+D-1 of the little-endian word stream
    function automatic logic [11:0] model(input int g, input int k);
        int d = dv[g];
        int x = 0;
        for (int b = 0; b < d; b++) begin
            int p = k * d + b;
            if (mem[g][p / W][p % W]) x |= (1 << b);
        end
        return 12'((3329 * x + (1 << (d - 1))) >> d);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int DG = (g == 0) ? 4 : (g == 1) ? 10 : 11;
        logic          busy, done, rd_en, we;
        logic [7:0]    addr, caddr;
        logic [W-1:0]  rd_data;
        logic [DG-1:0] dpi;
        logic [11:0]   dpo, cdata, p0, p1, p2;

        decompress_seq_ctrl #(.D(DG), .N(N), .W(W), .DP_LAT(4), .IN_AW(8)) u (
            .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
            .mem_rd_en(rd_en), .mem_addr(addr), .mem_rd_data(rd_data),
            .dp_in_val(dpi), .dp_out_val(dpo),
            .coef_we(we), .coef_addr(caddr), .coef_data(cdata)
        );

        always @(posedge clk) if (rd_en) rd_data <= mem[g][addr];

        always @(posedge clk) begin
            p0 <= 12'((3329 * int'(dpi) + (1 << (DG - 1))) >> DG);
            p1 <= p0;
            p2 <= p1;
        end
        assign dpo = p2;

        always @(negedge rst_n) begin
            #1;
            checks++;
            if ({busy, done, rd_en, we} != 0 || addr != 0 || dpi != 0 || caddr != 0 || cdata != 0) begin
                errors++;
                $display("FAIL async_reset D=%0d outputs busy=%b done=%b rd=%b we=%b not all zero", DG, busy, done, rd_en, we);
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                checks++;
                if ({busy, done, rd_en, we} != 0 || addr != 0 || dpi != 0 || caddr != 0 || cdata != 0) begin
                    errors++;
                    $display("FAIL reset_outputs D=%0d cyc=%0d busy=%b done=%b rd=%b we=%b", DG, cyc, busy, done, rd_en, we);
                end
            end else begin
                checks++;
                if (busy !== (active[g] && cyc > t0)) begin
                    errors++;
                    $display("FAIL busy D=%0d cyc=%0d got %b expected %b", DG, cyc, busy, active[g] && cyc > t0);
                end
                checks++;
                if (u.cnt > 2 * W) begin
                    errors++;
                    $display("FAIL buffer_count D=%0d cyc=%0d got %0d limit %0d", DG, cyc, u.cnt, 2 * W);
                end
                if (rd_en) begin
                    checks++;
                    if (!active[g] || int'(addr) != rd_idx[g] || rd_idx[g] >= words[g]) begin
                        errors++;
                        $display("FAIL read_addr D=%0d cyc=%0d got %0d expected %0d (active=%b)", DG, cyc, addr, rd_idx[g], active[g]);
                    end
                    if (rd_idx[g] == 0) begin
                        checks++;
                        if (cyc != t0 + 1) begin
                            errors++;
                            $display("FAIL first_read_time D=%0d got cycle %0d expected %0d", DG, cyc - t0, 1);
                        end
                    end
                    rd_idx[g]++;
                end
                if (we) begin
                    checks++;
                    if (exp_q[g].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write D=%0d cyc=%0d addr=%0d data=%0d", DG, cyc, caddr, cdata);
                    end else begin
                        logic [11:0] e;
                        e = exp_q[g].pop_front();
                        if (cdata != e || int'(caddr) != wr_idx[g]) begin
                            errors++;
                            $display("FAIL coef D=%0d got [%0d]=%0d expected [%0d]=%0d", DG, caddr, cdata, wr_idx[g], e);
                        end
                        checks++;
                        if (cyc != t0 + 7 + wr_idx[g]) begin
                            errors++;
                            $display("FAIL write_time D=%0d idx=%0d got T%0d expected T%0d", DG, wr_idx[g], cyc - t0, 7 + wr_idx[g]);
                        end
                        wr_idx[g]++;
                    end
                end
                if (done) begin
                    checks++;
                    if (!active[g] || cyc != t0 + N + 7 || wr_idx[g] != N || rd_idx[g] != words[g]) begin
                        errors++;
                        $display("FAIL done D=%0d got T%0d writes=%0d reads=%0d expected T%0d writes=%0d reads=%0d active=%b",
                                 DG, cyc - t0, wr_idx[g], rd_idx[g], N + 7, N, words[g], active[g]);
                    end
                    active[g] = 1'b0;
                end
            end
        end
    end

    task automatic launch(input int mode);
        for (int g = 0; g < 3; g++) begin
            words[g] = (N * dv[g] + W - 1) / W;
            if (mode != 2)
                for (int i = 0; i < 256; i++) mem[g][i] = $urandom;
            if (mode == 0 && g == 0) begin
                for (int i = 0; i < 256; i++) mem[g][i] = '0;
                mem[g][0] = 32'h7654_3210;
                mem[g][1] = 32'hFEDC_BA98;
            end
            exp_q[g].delete();
            for (int k = 0; k < N; k++) exp_q[g].push_back(model(g, k));
            rd_idx[g] = 0;
            wr_idx[g] = 0;
        end
        @(posedge clk);
        #1 start = 1'b1;
        t0 = cyc;
        active = '{1'b1, 1'b1, 1'b1};
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_at(input int t);
        while (cyc < t0 + t) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && (active[0] || active[1] || active[2]); i++) @(posedge clk);
        checks++;
        if (active[0] || active[1] || active[2]) begin
            errors++;
            $display("FAIL done_timeout active=%b%b%b after 400 cycles", active[0], active[1], active[2]);
            active = '{1'b0, 1'b0, 1'b0};
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        active = '{1'b0, 1'b0, 1'b0};
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        launch(0);
        wait_done();
        launch(1);
        pulse_at(50);
        pulse_at(200);
        wait_done();
        launch(2);
        wait_done();
        launch(1);
        while (cyc < t0 + 100) @(posedge clk);
        #2 rst_n = 1'b0;
        active = '{1'b0, 1'b0, 1'b0};
        for (int g = 0; g < 3; g++) exp_q[g].delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        launch(1);
        wait_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
